// File: rtl/tick_timer_pkg.sv
// tick_timer_pkg: shared constants and types for the tick_timer block.
//   - State encoding (IDLE=0, RUN=1, PAUSE=2, DONE=3) as an enum plus plain aliases.
//   - Count direction constants for the dir input.
package tick_timer_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam state_e IDLE  = StIdle;
  localparam state_e RUN   = StRun;
  localparam state_e PAUSE = StPause;
  localparam state_e DONE  = StDone;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: 32-bit free-running divider used to generate unit steps.
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   en_i    count enable; the counter holds its value while low
//   clr_i   synchronous clear to 0, wins over en_i
//   term_o  high in the cycle the counter sits at CLOCK_CYCLES-1 while enabled
module tick_prescaler #(
  parameter int unsigned CLOCK_CYCLES = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic term_o
);

  localparam logic [31:0] LastCnt = 32'(CLOCK_CYCLES - 1);

  logic [31:0] cnt_q, cnt_d;

  assign term_o = en_i && (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = term_o ? '0 : cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tick_timer.sv
// tick_timer: prescaled up/down unit counter with run/pause/done control.
//   clk, rst (async active-low)
//   start, pause       level run/pause requests
//   clear              synchronous clear, wins over everything but reset
//   dir                0 = up, 1 = down
//   load, load_val     preset (honoured in IDLE and PAUSE)
//   tick               toggles on every unit step
//   step               one-cycle pulse per unit step
//   unit_count         current count
//   wrap               one-cycle pulse when the up count rolls over to 0
//   done               high while in DONE
//   state              IDLE=0, RUN=1, PAUSE=2, DONE=3
// Optional lap capture (lap, lap_count, lap_valid) is built when TICK_TIMER_LAP_EN is defined.
// All outputs come straight from flops.
module tick_timer
  import tick_timer_pkg::*;
#(
  parameter int unsigned CLOCK_CYCLES = 50_000_000,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned MAX_COUNT    = 59
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  input  logic               clear,
  input  logic               dir,
  input  logic               load,
  input  logic [CNT_W-1:0]   load_val,
  output logic               tick,
  output logic               step,
  output logic [CNT_W-1:0]   unit_count,
  output logic               wrap,
  output logic               done,
`ifdef TICK_TIMER_LAP_EN
  input  logic               lap,
  output logic [CNT_W-1:0]   lap_count,
  output logic               lap_valid,
`endif
  output logic [STATE_W-1:0] state
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_COUNT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;

  logic presc_en, presc_clr, presc_term;

  assign presc_en = (state_q == StRun);

  tick_prescaler #(
    .CLOCK_CYCLES(CLOCK_CYCLES)
  ) u_prescaler (
    .clk_i (clk),
    .rst_ni(rst),
    .en_i  (presc_en),
    .clr_i (presc_clr),
    .term_o(presc_term)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tick_d    = tick_q;
    step_d    = 1'b0;
    wrap_d    = 1'b0;
    presc_clr = 1'b0;

    if (clear) begin
      state_d   = StIdle;
      cnt_d     = '0;
      tick_d    = 1'b0;
      presc_clr = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          presc_clr = 1'b1;
          if (load) cnt_d = load_val;
          if (start && !pause) state_d = StRun;
        end
        StRun: begin
          if (!start && !pause) begin
            state_d   = StIdle;
            cnt_d     = '0;
            presc_clr = 1'b1;
          end else if (dir == DIR_DOWN && cnt_q == '0) begin
            // Terminal down count: no step, park in DONE.
            state_d   = StDone;
            presc_clr = 1'b1;
          end else begin
            if (presc_term) begin
              step_d = 1'b1;
              tick_d = ~tick_q;
              if (dir == DIR_UP) begin
                // A preset above MaxCnt runs on to all-ones and wraps there.
                if (cnt_q == MaxCnt || cnt_q == '1) begin
                  cnt_d  = '0;
                  wrap_d = 1'b1;
                end else begin
                  cnt_d = cnt_q + CNT_W'(1);
                end
              end else begin
                cnt_d = cnt_q - CNT_W'(1);
              end
            end
            // A step landing in the pause cycle still completes above.
            if (start && pause) state_d = StPause;
          end
        end
        StPause: begin
          if (load) cnt_d = load_val;
          if (start && !pause) state_d = StRun;
        end
        StDone: begin
          cnt_d     = '0;
          presc_clr = 1'b1;
        end
        default: begin
          state_d   = StIdle;
          presc_clr = 1'b1;
        end
      endcase
    end

    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign state      = state_q;
  assign unit_count = cnt_q;
  assign tick       = tick_q;
  assign step       = step_q;
  assign wrap       = wrap_q;
  assign done       = done_q;

`ifdef TICK_TIMER_LAP_EN
  logic [CNT_W-1:0] lap_count_q, lap_count_d;
  logic             lap_valid_q, lap_valid_d;

  always_comb begin
    lap_count_d = lap_count_q;
    lap_valid_d = lap_valid_q;
    if (clear) begin
      lap_count_d = '0;
      lap_valid_d = 1'b0;
    end else if (state_q == StRun && lap) begin
      lap_count_d = cnt_q;
      lap_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lap_count_q <= '0;
      lap_valid_q <= 1'b0;
    end else begin
      lap_count_q <= lap_count_d;
      lap_valid_q <= lap_valid_d;
    end
  end

  assign lap_count = lap_count_q;
  assign lap_valid = lap_valid_q;
`endif

endmodule

// File: tb/tb_tick_timer.sv
// tb_tick_timer: self-checking bench for tick_timer (CLOCK_CYCLES=4, CNT_W=4, MAX_COUNT=5).
// A cycle model predicts every registered output; predictions are queued before each clock
// edge and compared after it. Directed checks cover the scenario-level expectations.
module tb_tick_timer;

  localparam int unsigned CC = 4;
  localparam int unsigned CW = 4;
  localparam int unsigned MC = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0, pause = 1'b0, clear = 1'b0, dir = 1'b0, load = 1'b0;
  logic [CW-1:0] load_val = '0;
  logic          lap_in = 1'b0;
  logic          tick, step, wrap, done;
  logic [CW-1:0] unit_count;
  logic [1:0]    state;
`ifdef TICK_TIMER_LAP_EN
  logic [CW-1:0] lap_count;
  logic          lap_valid;
`endif

  always #5 clk = ~clk;

  tick_timer #(
    .CLOCK_CYCLES(CC),
    .CNT_W       (CW),
    .MAX_COUNT   (MC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pause     (pause),
    .clear     (clear),
    .dir       (dir),
    .load      (load),
    .load_val  (load_val),
    .tick      (tick),
    .step      (step),
    .unit_count(unit_count),
    .wrap      (wrap),
    .done      (done),
`ifdef TICK_TIMER_LAP_EN
    .lap       (lap_in),
    .lap_count (lap_count),
    .lap_valid (lap_valid),
`endif
    .state     (state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state.
  logic [1:0]    m_state = 2'd0;
  logic [CW-1:0] m_cnt   = '0;
  logic          m_tick  = 1'b0;
  int unsigned   m_presc = 0;
  logic [CW-1:0] m_lap_cnt = '0;
  logic          m_lap_v   = 1'b0;

  logic [15:0] exp_q[$];

  function automatic logic [15:0] dut_outs();
`ifdef TICK_TIMER_LAP_EN
    return {1'b0, lap_valid, lap_count, state, done, wrap, unit_count, step, tick};
`else
    return {6'b0, state, done, wrap, unit_count, step, tick};
`endif
  endfunction

  task automatic model_next(output logic [15:0] e);
    logic [1:0]    ns;
    logic [CW-1:0] nc, nlc;
    logic          nt, nstep, nwrap, nlv, term;
    int unsigned   np;
    ns = m_state; nc = m_cnt; nt = m_tick; np = m_presc;
    nlc = m_lap_cnt; nlv = m_lap_v; nstep = 1'b0; nwrap = 1'b0;
    term = (m_state == 2'd1) && (m_presc == CC - 1);
    if (clear) begin
      ns = 2'd0; nc = '0; nt = 1'b0; np = 0; nlc = '0; nlv = 1'b0;
    end else begin
      case (m_state)
        2'd0: begin
          np = 0;
          if (load) nc = load_val;
          if (start && !pause) ns = 2'd1;
        end
        2'd1: begin
          if (lap_in) begin nlc = m_cnt; nlv = 1'b1; end
          if (!start && !pause) begin
            ns = 2'd0; nc = '0; np = 0;
          end else if (dir && m_cnt == '0) begin
            ns = 2'd3; np = 0;
          end else begin
            np = term ? 0 : m_presc + 1;
            if (term) begin
              nstep = 1'b1;
              nt    = ~m_tick;
              if (!dir) begin
                if (m_cnt == CW'(MC) || m_cnt == {CW{1'b1}}) begin
                  nc = '0; nwrap = 1'b1;
                end else begin
                  nc = m_cnt + 1'b1;
                end
              end else begin
                nc = m_cnt - 1'b1;
              end
            end
            if (start && pause) ns = 2'd2;
          end
        end
        2'd2: begin
          if (load) nc = load_val;
          if (start && !pause) ns = 2'd1;
        end
        default: begin nc = '0; np = 0; end
      endcase
    end
    m_state = ns; m_cnt = nc; m_tick = nt; m_presc = np; m_lap_cnt = nlc; m_lap_v = nlv;
`ifdef TICK_TIMER_LAP_EN
    e = {1'b0, nlv, nlc, ns, (ns == 2'd3), nwrap, nc, nstep, nt};
`else
    e = {6'b0, ns, (ns == 2'd3), nwrap, nc, nstep, nt};
`endif
  endtask

  task automatic model_reset();
    m_state = 2'd0; m_cnt = '0; m_tick = 1'b0; m_presc = 0; m_lap_cnt = '0; m_lap_v = 1'b0;
    exp_q.delete();
  endtask

  // One clock: predict, push, clock, pop and compare.
  task automatic cycle();
    logic [15:0] e;
    model_next(e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check("outs", {16'b0, dut_outs()}, {16'b0, exp_q.pop_front()});
  endtask

  task automatic wait_step(input string tag, input int budget);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!step && n < budget);
    if (!step) check(tag, 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int steps, wraps, tog, n;
    logic prev_tick;
    logic [CW-1:0] up_seq[6];
    logic [CW-1:0] dn_seq[3];
    up_seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0};
    dn_seq = '{4'd2, 4'd1, 4'd0};

    // Power-on reset
    repeat (2) @(negedge clk);
    check("reset_outs", {16'b0, dut_outs()}, 32'd0);
    rst = 1'b1;
    cycle();

    // Up count through the wrap
    start = 1'b1; dir = 1'b0;
    steps = 0; wraps = 0; tog = 0; prev_tick = tick;
    for (int i = 0; i < 25; i++) begin
      cycle();
      if (tick != prev_tick) tog++;
      prev_tick = tick;
      if (step) begin
        if (steps < 6) check("up_seq", {28'b0, unit_count}, {28'b0, up_seq[steps]});
        if (wrap) begin
          wraps++;
          check("wrap_val", {28'b0, unit_count}, 32'd0);
        end
        steps++;
      end
    end
    check("up_steps", steps, 6);
    check("up_wraps", wraps, 1);
    check("tick_toggles", tog, 6);

    clear = 1'b1; start = 1'b0;
    cycle();
    clear = 1'b0;
    check("clr_state", {30'b0, state}, 32'd0);
    check("clr_cnt", {28'b0, unit_count}, 32'd0);

    // Preset then count down to DONE
    load = 1'b1; load_val = 4'd3;
    cycle();
    load = 1'b0;
    check("load_idle", {28'b0, unit_count}, 32'd3);
    dir = 1'b1; start = 1'b1;
    steps = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (step) begin
        if (steps < 3) check("dn_seq", {28'b0, unit_count}, {28'b0, dn_seq[steps]});
        steps++;
      end
      if (done) break;
    end
    check("dn_steps", steps, 3);
    check("done_state", {30'b0, state}, 32'd3);
    check("done_flag", {31'b0, done}, 32'd1);
    cycle();
    check("done_hold", {30'b0, state}, 32'd3);
    clear = 1'b1; start = 1'b0; dir = 1'b0;
    cycle();
    clear = 1'b0;
    check("done_clr_state", {30'b0, state}, 32'd0);
    check("done_clr_cnt", {28'b0, unit_count}, 32'd0);

    // Pause with the prescaler at 2, then resume
    start = 1'b1;
    repeat (3) cycle();
    pause = 1'b1;
    steps = 0;
    for (int i = 0; i < 11; i++) begin
      cycle();
      if (step) steps++;
    end
    check("pause_state", {30'b0, state}, 32'd2);
    check("pause_cnt", {28'b0, unit_count}, 32'd0);
    check("pause_steps", steps, 0);
    pause = 1'b0;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!step && n < 10);
    check("resume_latency", n, 2);
    check("resume_cnt", {28'b0, unit_count}, 32'd1);

    // Stop from RUN at count 4, then clear with start held
    for (int i = 0; i < 3; i++) wait_step("to4_timeout", 10);
    check("reach4", {28'b0, unit_count}, 32'd4);
    start = 1'b0;
    cycle();
    check("stop_state", {30'b0, state}, 32'd0);
    check("stop_cnt", {28'b0, unit_count}, 32'd0);
    clear = 1'b1; start = 1'b1;
    cycle();
    check("clr_start_state", {30'b0, state}, 32'd0);
    clear = 1'b0; start = 1'b0;
    cycle();

    // Preset above MAX_COUNT wraps at all-ones
    load = 1'b1; load_val = 4'd14;
    cycle();
    load = 1'b0; start = 1'b1;
    wait_step("big1_timeout", 10);
    check("big_15", {27'b0, wrap, unit_count}, 32'd15);
    wait_step("big2_timeout", 10);
    check("big_wrap", {27'b0, wrap, unit_count}, 32'h10);
    clear = 1'b1; start = 1'b0;
    cycle();
    clear = 1'b0;

`ifdef TICK_TIMER_LAP_EN
    // Lap capture in RUN, ignored in PAUSE
    start = 1'b1;
    wait_step("lap_s1", 10);
    wait_step("lap_s2", 10);
    lap_in = 1'b1;
    cycle();
    lap_in = 1'b0;
    check("lap_count", {28'b0, lap_count}, 32'd2);
    check("lap_valid", {31'b0, lap_valid}, 32'd1);
    wait_step("lap_s3", 10);
    check("lap_cnt3", {28'b0, unit_count}, 32'd3);
    check("lap_hold", {28'b0, lap_count}, 32'd2);
    pause = 1'b1;
    cycle();
    lap_in = 1'b1;
    cycle();
    lap_in = 1'b0;
    check("lap_pause", {28'b0, lap_count}, 32'd2);
    pause = 1'b0; clear = 1'b1; start = 1'b0;
    cycle();
    clear = 1'b0;
`endif

    // Asynchronous reset mid-RUN with count 3
    start = 1'b1; dir = 1'b0;
    for (int i = 0; i < 3; i++) wait_step("rst_run_timeout", 10);
    check("pre_rst_cnt", {28'b0, unit_count}, 32'd3);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst", {16'b0, dut_outs()}, 32'd0);
    model_reset();
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cycle();
    check("post_rst_state", {30'b0, state}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
